// File: rtl/xadc_drp_sampler.sv
// xadc_drp_sampler: DRP read master for the XADC wizard. Each end-of-conversion
// triggers one DRP read of the switch-selected channel. The 12-bit result is
// captured, and block averages of 2**AVG_LOG2 samples are produced.
module xadc_drp_sampler #(
   parameter int AVG_LOG2       = 3,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic        CLK100MHZ,
   input  logic        reset_in,
   input  logic        eoc_in,
   input  logic [3:0]  channel_sel,
   output logic [6:0]  daddr_out,
   output logic        den_out,
   input  logic        drdy_in,
   input  logic [15:0] do_in,
   output logic [11:0] sample_out,
   output logic        sample_valid,
   output logic [11:0] avg_out,
   output logic        avg_valid,
   output logic        timeout_err
);

   localparam int ACC_W = 12 + AVG_LOG2;
   localparam int CNT_W = AVG_LOG2 + 1;
   localparam int TO_W  = $clog2(TIMEOUT_CYCLES);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);
   localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2
   } state_t;

   state_t state_q, state_d;

   logic [6:0]       daddr_q, daddr_d;
   logic             den_q, den_d;
   logic [11:0]      sample_q, sample_d;
   logic             sample_valid_q, sample_valid_d;
   logic [11:0]      avg_q, avg_d;
   logic             avg_valid_q, avg_valid_d;
   logic             timeout_err_q, timeout_err_d;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [TO_W-1:0]  tcnt_q, tcnt_d;
   logic [3:0]       chan_q, chan_d;

   logic [11:0]      new_sample;
   logic [ACC_W-1:0] acc_sum;
   logic             unused_do_lsb;

   assign new_sample    = do_in[15:4];
   assign acc_sum       = acc_q + ACC_W'(new_sample);
   assign unused_do_lsb = ^do_in[3:0];

   function automatic logic [6:0] chan_addr(input logic [3:0] code);
      logic [6:0] addr;
      case (code)
         4'd0:    addr = 7'h10;
         4'd1:    addr = 7'h11;
         4'd2:    addr = 7'h19;
         4'd3:    addr = 7'h12;
         4'd4:    addr = 7'h1A;
         4'd5:    addr = 7'h1B;
         4'd6:    addr = 7'h18;
         4'd7:    addr = 7'h13;
         4'd8:    addr = 7'h03;
         default: addr = 7'h10;
      endcase
      return addr;
   endfunction

   // FSM state register
   always_ff @(posedge CLK100MHZ or posedge reset_in) begin
      if (reset_in) state_q <= ST_IDLE;
      else          state_q <= state_d;
   end

   // FSM next-state: drdy wins over timeout in the same WAIT cycle
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (eoc_in) state_d = ST_REQ;
         ST_REQ:  state_d = ST_WAIT;
         ST_WAIT: begin
            if (drdy_in)                  state_d = ST_IDLE;
            else if (tcnt_q == TO_LAST)   state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Outputs and datapath next values; every output is registered, so den
   // appears the cycle after REQ and results the cycle after drdy
   always_comb begin
      daddr_d        = daddr_q;
      den_d          = 1'b0;
      sample_d       = sample_q;
      sample_valid_d = 1'b0;
      avg_d          = avg_q;
      avg_valid_d    = 1'b0;
      timeout_err_d  = 1'b0;
      acc_d          = acc_q;
      cnt_d          = cnt_q;
      tcnt_d         = tcnt_q;
      chan_d         = chan_q;
      case (state_q)
         ST_IDLE: begin
            if (eoc_in) begin
               chan_d  = channel_sel;
               daddr_d = chan_addr(channel_sel);
               if (channel_sel != chan_q) begin
                  acc_d = '0;
                  cnt_d = '0;
               end
            end
         end
         ST_REQ: begin
            den_d  = 1'b1;
            tcnt_d = '0;
         end
         ST_WAIT: begin
            if (drdy_in) begin
               sample_d       = new_sample;
               sample_valid_d = 1'b1;
               if (cnt_q == CNT_LAST) begin
                  avg_d       = acc_sum[ACC_W-1:AVG_LOG2];
                  avg_valid_d = 1'b1;
                  acc_d       = '0;
                  cnt_d       = '0;
               end else begin
                  acc_d = acc_sum;
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end else if (tcnt_q == TO_LAST) begin
               timeout_err_d = 1'b1;
            end else begin
               tcnt_d = tcnt_q + TO_W'(1);
            end
         end
         default: ;
      endcase
   end

   // Datapath and output registers
   always_ff @(posedge CLK100MHZ or posedge reset_in) begin
      if (reset_in) begin
         daddr_q        <= 7'h10;
         den_q          <= 1'b0;
         sample_q       <= '0;
         sample_valid_q <= 1'b0;
         avg_q          <= '0;
         avg_valid_q    <= 1'b0;
         timeout_err_q  <= 1'b0;
         acc_q          <= '0;
         cnt_q          <= '0;
         tcnt_q         <= '0;
         chan_q         <= '0;
      end else begin
         daddr_q        <= daddr_d;
         den_q          <= den_d;
         sample_q       <= sample_d;
         sample_valid_q <= sample_valid_d;
         avg_q          <= avg_d;
         avg_valid_q    <= avg_valid_d;
         timeout_err_q  <= timeout_err_d;
         acc_q          <= acc_d;
         cnt_q          <= cnt_d;
         tcnt_q         <= tcnt_d;
         chan_q         <= chan_d;
      end
   end

   assign daddr_out    = daddr_q;
   assign den_out      = den_q;
   assign sample_out   = sample_q;
   assign sample_valid = sample_valid_q;
   assign avg_out      = avg_q;
   assign avg_valid    = avg_valid_q;
   assign timeout_err  = timeout_err_q;

endmodule

// File: tb/tb_xadc_drp_sampler.sv
// Testbench for xadc_drp_sampler: table-driven vectors, hand-written corner
// sequences and a randomized phase against a transaction-level model.
module tb_xadc_drp_sampler;

   localparam int L = 2;
   localparam int T = 16;
   localparam int N = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        eoc;
   logic [3:0]  chs;
   logic        drdy;
   logic [15:0] dio;
   logic [6:0]  daddr_out;
   logic        den_out;
   logic [11:0] sample_out;
   logic        sample_valid;
   logic [11:0] avg_out;
   logic        avg_valid;
   logic        timeout_err;

   always #5 clk = ~clk;

   xadc_drp_sampler #(.AVG_LOG2(L), .TIMEOUT_CYCLES(T)) dut (
      .CLK100MHZ    (clk),
      .reset_in     (rst),
      .eoc_in       (eoc),
      .channel_sel  (chs),
      .daddr_out    (daddr_out),
      .den_out      (den_out),
      .drdy_in      (drdy),
      .do_in        (dio),
      .sample_out   (sample_out),
      .sample_valid (sample_valid),
      .avg_out      (avg_out),
      .avg_valid    (avg_valid),
      .timeout_err  (timeout_err)
   );

   int checks = 0;
   int errors = 0;
   int den_cnt = 0;

   // den_out pulses counted away from the active edge
   always @(negedge clk) if (den_out) den_cnt++;

   logic [6:0] map_tbl [0:15];

   typedef struct {
      logic [3:0]  ch;
      logic [15:0] data;
      int          lat;
      logic [6:0]  e_daddr;
      logic [11:0] e_sample;
      logic        e_av;
      logic [11:0] e_avg;
   } vec_t;
   vec_t vecs[$];

   // model state
   logic [3:0]  m_chan;
   int          m_q[$];
   logic [11:0] m_sample;
   logic [11:0] m_avg;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
      end
   endtask

   function automatic logic eoc_val(input int mode);
      if (mode == 2) return 1'b1;
      if (mode == 1) return 1'($urandom_range(0, 1));
      return 1'b0;
   endfunction

   // One DRP transaction: eoc, den check, drdy after lat WAIT cycles (or none if lat>=T)
   task automatic do_read(input logic [3:0] ch, input logic [15:0] data, input int lat,
                          input int mode,
                          output logic [6:0] o_daddr, output logic o_sv,
                          output logic [11:0] o_sample, output logic o_av,
                          output logic [11:0] o_avg, output logic o_to);
      int d0;
      logic early;
      d0 = den_cnt;
      early = 1'b0;
      eoc = 1'b1;
      chs = ch;
      tick();
      eoc = 1'b0;
      check("den_early", den_out, 0);
      tick();
      check("den_pulse", den_out, 1);
      o_daddr = daddr_out;
      if (lat < T) begin
         for (int i = 0; i < lat; i++) begin
            eoc = eoc_val(mode);
            tick();
            early |= sample_valid | timeout_err | den_out;
         end
         drdy = 1'b1;
         dio = data;
         eoc = eoc_val(mode);
         tick();
         drdy = 1'b0;
         dio = 16'($urandom);
      end else begin
         for (int i = 0; i < T; i++) begin
            eoc = eoc_val(mode);
            tick();
            if (i < T - 1) early |= sample_valid | timeout_err | den_out;
         end
      end
      eoc = 1'b0;
      o_sv = sample_valid;
      o_sample = sample_out;
      o_av = avg_valid;
      o_avg = avg_out;
      o_to = timeout_err;
      check("early_pulse", early, 0);
      check("den_count", den_cnt - d0, 1);
   endtask

   // Idle cycles with stray drdy pulses; nothing may move
   task automatic gap(input int n, input logic [11:0] hs, input logic [11:0] ha);
      logic bad;
      bad = 1'b0;
      for (int i = 0; i < n; i++) begin
         drdy = 1'($urandom_range(0, 1));
         dio = 16'($urandom);
         tick();
         bad |= sample_valid | avg_valid | den_out | timeout_err;
         bad |= (sample_out != hs) | (avg_out != ha);
      end
      drdy = 1'b0;
      if (n > 0) check("idle_quiet", bad, 0);
   endtask

   task automatic check_reset_vals(input string nm);
      check({nm, "_daddr"}, daddr_out, 7'h10);
      check({nm, "_den"}, den_out, 0);
      check({nm, "_sample"}, sample_out, 0);
      check({nm, "_sv"}, sample_valid, 0);
      check({nm, "_avg"}, avg_out, 0);
      check({nm, "_av"}, avg_valid, 0);
      check({nm, "_to"}, timeout_err, 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [6:0]  g_daddr;
      logic        g_sv, g_av, g_to;
      logic [11:0] g_sample, g_avg;
      logic [3:0]  ch;
      logic [15:0] data;
      int          lat, d0, sum;
      logic        e_to, e_av;

      map_tbl = '{7'h10, 7'h11, 7'h19, 7'h12, 7'h1A, 7'h1B, 7'h18, 7'h13,
                  7'h03, 7'h10, 7'h10, 7'h10, 7'h10, 7'h10, 7'h10, 7'h10};

      // {ch, do_in, drdy latency, daddr, sample, avg_valid, avg}
      vecs.push_back('{4'd0, 16'hFFF0, 0,     7'h10, 12'hFFF, 1'b0, 12'h000});
      vecs.push_back('{4'd0, 16'h0010, 3,     7'h10, 12'h001, 1'b0, 12'h000});
      vecs.push_back('{4'd0, 16'h8000, 1,     7'h10, 12'h800, 1'b0, 12'h000});
      vecs.push_back('{4'd0, 16'h4000, T - 1, 7'h10, 12'h400, 1'b1, 12'h700});
      vecs.push_back('{4'd5, 16'h0120, 0,     7'h1B, 12'h012, 1'b0, 12'h700});
      vecs.push_back('{4'd5, 16'h0340, 2,     7'h1B, 12'h034, 1'b0, 12'h700});
      vecs.push_back('{4'd7, 16'h1000, 0,     7'h13, 12'h100, 1'b0, 12'h700});
      vecs.push_back('{4'd7, 16'h2000, 4,     7'h13, 12'h200, 1'b0, 12'h700});
      vecs.push_back('{4'd7, 16'h3000, 0,     7'h13, 12'h300, 1'b0, 12'h700});
      vecs.push_back('{4'd7, 16'h4010, 1,     7'h13, 12'h401, 1'b1, 12'h280});
      vecs.push_back('{4'd9, 16'hABCD, 0,     7'h10, 12'hABC, 1'b0, 12'h280});

      rst = 1'b1; eoc = 1'b0; chs = 4'd0; drdy = 1'b0; dio = '0;
      tick(); tick();
      check_reset_vals("reset");
      rst = 1'b0;
      tick();

      // Table-driven reads
      foreach (vecs[i]) begin
         do_read(vecs[i].ch, vecs[i].data, vecs[i].lat, 0,
                 g_daddr, g_sv, g_sample, g_av, g_avg, g_to);
         check($sformatf("vec%0d_daddr", i), g_daddr, vecs[i].e_daddr);
         check($sformatf("vec%0d_sv", i), g_sv, 1);
         check($sformatf("vec%0d_sample", i), g_sample, vecs[i].e_sample);
         check($sformatf("vec%0d_av", i), g_av, vecs[i].e_av);
         check($sformatf("vec%0d_avg", i), g_avg, vecs[i].e_avg);
         check($sformatf("vec%0d_to", i), g_to, 0);
         gap(2, vecs[i].e_sample, vecs[i].e_avg);
      end

      // Timeout: no sample, accumulator untouched, next read proceeds
      do_read(4'd9, 16'h0000, T, 0, g_daddr, g_sv, g_sample, g_av, g_avg, g_to);
      check("to_pulse", g_to, 1);
      check("to_sv", g_sv, 0);
      check("to_sample_hold", g_sample, 12'hABC);
      tick();
      check("to_one_cycle", timeout_err, 0);
      do_read(4'd9, 16'h5550, 2, 0, g_daddr, g_sv, g_sample, g_av, g_avg, g_to);
      check("after_to_sv", g_sv, 1);
      check("after_to_sample", g_sample, 12'h555);
      check("after_to_av", g_av, 0);
      do_read(4'd9, 16'h1110, 0, 0, g_daddr, g_sv, g_sample, g_av, g_avg, g_to);
      check("after_to_av2", g_av, 0);
      do_read(4'd9, 16'h2220, 0, 0, g_daddr, g_sv, g_sample, g_av, g_avg, g_to);
      check("after_to_av3", g_av, 1);
      check("after_to_avg", g_avg, 12'h4D1);

      // Channel sweep
      for (int c = 0; c < 16; c++) begin
         do_read(4'(c), 16'($urandom), 0, 0, g_daddr, g_sv, g_sample, g_av, g_avg, g_to);
         check($sformatf("sweep%0d_daddr", c), g_daddr, map_tbl[c]);
         check($sformatf("sweep%0d_sv", c), g_sv, 1);
      end

      // eoc held high through WAIT: still only one den pulse
      do_read(4'd2, 16'h1230, 5, 2, g_daddr, g_sv, g_sample, g_av, g_avg, g_to);
      check("eoc_wait_sample", g_sample, 12'h123);
      tick();
      check("eoc_wait_no_den", den_out, 0);

      // Reset during WAIT, then a late drdy
      d0 = den_cnt;
      eoc = 1'b1; chs = 4'd3;
      tick();
      eoc = 1'b0;
      tick(); tick();
      rst = 1'b1;
      #1;
      check_reset_vals("midrst");
      tick();
      rst = 1'b0;
      tick();
      drdy = 1'b1; dio = 16'h7770;
      tick();
      drdy = 1'b0;
      check_reset_vals("late_drdy");
      tick();
      check_reset_vals("late_drdy2");
      check("midrst_den_count", den_cnt - d0, 1);

      // Randomized phase against the transaction-level model
      m_chan = 4'd0; m_q.delete(); m_sample = '0; m_avg = '0;
      for (int r = 0; r < 150; r++) begin
         ch   = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : m_chan;
         data = 16'($urandom);
         lat  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(T - 1, T + 1))
                                            : int'($urandom_range(0, 4));
         do_read(ch, data, lat, int'($urandom_range(0, 1)),
                 g_daddr, g_sv, g_sample, g_av, g_avg, g_to);
         if (ch != m_chan) begin
            m_q.delete();
            m_chan = ch;
         end
         e_to = (lat >= T);
         e_av = 1'b0;
         if (!e_to) begin
            m_sample = data[15:4];
            m_q.push_back(int'(data[15:4]));
            if (m_q.size() == N) begin
               sum = 0;
               foreach (m_q[k]) sum += m_q[k];
               m_avg = 12'(sum / N);
               e_av = 1'b1;
               m_q.delete();
            end
         end
         check("rnd_daddr", g_daddr, map_tbl[ch]);
         check("rnd_sv", g_sv, !e_to);
         check("rnd_sample", g_sample, m_sample);
         check("rnd_av", g_av, e_av);
         check("rnd_avg", g_avg, m_avg);
         check("rnd_to", g_to, e_to);
         gap(int'($urandom_range(0, 3)), m_sample, m_avg);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
